// File: rtl/framebuffer_pkg.sv
// Shared constants and types for the SDRAM frame-buffer read path.
// Frames are stored as whole SDRAM rows of 1024 words each.
package framebuffer_pkg;

    localparam int PIXELS_PER_FRAME       = 307200;
    localparam int COLS_PER_ROW           = 1024;
    localparam int DEFAULT_NUM_FRAME      = 16;
    localparam int DEFAULT_ROWS_PER_FRAME = 300;

    localparam int ADDR_W = 25;
    localparam int ROW_W  = 15;
    localparam int COL_W  = 10;
    localparam int DATA_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } reader_state_t;

endpackage

// File: rtl/frame_reader_if.sv
// SDRAM read-request bus plus the outgoing pixel stream of the frame reader.
// The master side is the reader; the slave side is controller plus display.
interface frame_reader_if;
    import framebuffer_pkg::*;

    logic              read;
    logic [ADDR_W-1:0] address;
    logic              keepOpen;
    logic              busy;
    logic              readValid;
    logic [DATA_W-1:0] readData;

    logic [DATA_W-1:0] pixelData;
    logic              pixelValid;
    logic              pixelReady;
    logic              pixelLast;

    modport master (
        output read, address, keepOpen, pixelData, pixelValid, pixelLast,
        input  busy, readValid, readData, pixelReady
    );

    modport slave (
        input  read, address, keepOpen, pixelData, pixelValid, pixelLast,
        output busy, readValid, readData, pixelReady
    );

endinterface

// File: rtl/pixel_fifo.sv
// Synchronous first-word-fall-through FIFO; the head is visible the cycle after
// it is written. count feeds the reader's credit check.
module pixel_fifo #(
    parameter  int WIDTH = 10,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count_reg != '0);
    // A push into a full FIFO is fine as long as the head leaves in the same cycle.
    assign do_push = push && ((count_reg != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= (wr_ptr_reg == AW'(DEPTH - 1)) ? '0 : wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= (rd_ptr_reg == AW'(DEPTH - 1)) ? '0 : rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign valid = (count_reg != '0);
    assign dout  = valid ? mem[rd_ptr_reg] : '0;
    assign count = count_reg;

endmodule

// File: rtl/frame_reader.sv
// Plays back the most recently completed frame of the SDRAM ring as a pixel
// stream, issuing credit-limited single-word reads in row/column order.
module frame_reader
    import framebuffer_pkg::*;
#(
    parameter int NUM_FRAME      = DEFAULT_NUM_FRAME,
    parameter int ROWS_PER_FRAME = DEFAULT_ROWS_PER_FRAME,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic              ram_clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ROW_W-1:0]  lastframe,
    output logic              active,
    output logic              done,
    frame_reader_if.master    bus
);

    // With the default geometry PIXELS equals PIXELS_PER_FRAME.
    localparam int PIXELS = ROWS_PER_FRAME * COLS_PER_ROW;
    localparam int PIX_W  = $clog2(PIXELS);
    localparam int CW     = $clog2(FIFO_DEPTH + 1);

    localparam logic [PIX_W-1:0] LAST_PIX  = PIX_W'(PIXELS - 1);
    localparam logic [8:0]       LAST_ROW  = 9'(ROWS_PER_FRAME - 1);
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(COLS_PER_ROW - 1);
    localparam logic [ROW_W-1:0] FRAME_ROWS = ROW_W'(ROWS_PER_FRAME);
    localparam logic [ROW_W-1:0] BASE_WRAP = ROW_W'((NUM_FRAME - 1) * ROWS_PER_FRAME);

    reader_state_t     state_reg, state_next;
    logic [ROW_W-1:0]  base_reg, base_next;
    logic [8:0]        row_reg, row_next;
    logic [COL_W-1:0]  col_reg, col_next;
    logic [CW-1:0]     outstanding_reg, outstanding_next;
    logic [PIX_W-1:0]  pix_cnt_reg, pix_cnt_next;
    logic [ADDR_W-1:0] address_reg, address_next;
    logic              keep_open_reg, keep_open_next;
    logic              done_reg, done_next;

    logic [DATA_W-1:0] fifo_data;
    logic              fifo_valid;
    logic [CW-1:0]     fifo_count;
    logic              credit_ok;
    logic              accept;
    logic              ret_ok;
    logic              pix_hs;

    // Words in flight plus words buffered may never exceed the FIFO depth.
    assign credit_ok = ({1'b0, outstanding_reg} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH);
    assign bus.read  = (state_reg == READ) && credit_ok;
    assign accept    = bus.read && !bus.busy;
    assign ret_ok    = bus.readValid && (outstanding_reg != '0);
    assign pix_hs    = fifo_valid && bus.pixelReady;

    pixel_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (ram_clk),
        .srst  (reset),
        .push  (ret_ok),
        .din   (bus.readData),
        .pop   (bus.pixelReady),
        .dout  (fifo_data),
        .valid (fifo_valid),
        .count (fifo_count)
    );

    always_comb begin
        state_next       = state_reg;
        base_next        = base_reg;
        row_next         = row_reg;
        col_next         = col_reg;
        outstanding_next = outstanding_reg;
        pix_cnt_next     = pix_cnt_reg;
        address_next     = address_reg;
        keep_open_next   = keep_open_reg;
        done_next        = 1'b0;

        case ({accept, ret_ok})
            2'b10:   outstanding_next = outstanding_reg + CW'(1);
            2'b01:   outstanding_next = outstanding_reg - CW'(1);
            default: outstanding_next = outstanding_reg;
        endcase
        if (pix_hs) begin
            pix_cnt_next = pix_cnt_reg + PIX_W'(1);
        end

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next       = READ;
                    base_next        = (lastframe == '0) ? BASE_WRAP : lastframe - FRAME_ROWS;
                    row_next         = '0;
                    col_next         = '0;
                    outstanding_next = '0;
                    pix_cnt_next     = '0;
                    address_next     = {base_next, {COL_W{1'b0}}};
                    keep_open_next   = 1'b1;
                end
            end
            READ: begin
                if (accept) begin
                    col_next = col_reg + COL_W'(1);
                    if (col_reg == LAST_COL) begin
                        row_next = row_reg + 9'd1;
                        if (row_reg == LAST_ROW) begin
                            state_next = DRAIN;
                        end
                    end
                    // The last issued address stays on the bus once reads stop.
                    if (state_next == READ) begin
                        address_next   = {base_reg + ROW_W'(row_next), col_next};
                        keep_open_next = (col_next != LAST_COL);
                    end else begin
                        keep_open_next = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (pix_hs && (pix_cnt_reg == LAST_PIX)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ram_clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            base_reg        <= '0;
            row_reg         <= '0;
            col_reg         <= '0;
            outstanding_reg <= '0;
            pix_cnt_reg     <= '0;
            address_reg     <= '0;
            keep_open_reg   <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            base_reg        <= base_next;
            row_reg         <= row_next;
            col_reg         <= col_next;
            outstanding_reg <= outstanding_next;
            pix_cnt_reg     <= pix_cnt_next;
            address_reg     <= address_next;
            keep_open_reg   <= keep_open_next;
            done_reg        <= done_next;
        end
    end

    assign bus.address    = address_reg;
    assign bus.keepOpen   = keep_open_reg;
    assign bus.pixelData  = fifo_data;
    assign bus.pixelValid = fifo_valid;
    assign bus.pixelLast  = fifo_valid && (pix_cnt_reg == LAST_PIX);
    assign active         = (state_reg != IDLE);
    assign done           = done_reg;

endmodule

// File: tb/tb_frame_reader.sv
// Scoreboard bench for frame_reader with a fixed-latency SDRAM model.
// Uses a 2-row frame geometry so complete frames stay short.
module tb_frame_reader;
    import framebuffer_pkg::*;

    localparam int NF  = 16;
    localparam int RPF = 2;
    localparam int FD  = 16;
    localparam int LAT = 3;
    localparam int PIX = RPF * 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [14:0] lastframe = '0;
    logic        active;
    logic        done;

    logic        mdl_valid = 1'b0;
    logic [9:0]  mdl_data = '0;
    logic        inj_valid = 1'b0;
    logic [9:0]  inj_data = '0;

    int checks = 0;
    int errors = 0;
    int acc_total = 0;
    int hs_total = 0;
    int done_total = 0;

    logic [24:0] req_q[$];
    logic [10:0] pix_q[$];

    frame_reader_if bus();

    assign bus.readValid = mdl_valid | inj_valid;
    assign bus.readData  = inj_valid ? inj_data : mdl_data;

    frame_reader #(
        .NUM_FRAME      (NF),
        .ROWS_PER_FRAME (RPF),
        .FIFO_DEPTH     (FD)
    ) dut (
        .ram_clk   (clk),
        .reset     (reset),
        .start     (start),
        .lastframe (lastframe),
        .active    (active),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] word_of(input logic [24:0] a);
        return a[9:0] ^ a[19:10] ^ 10'h155;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected request addresses and pixel words for one whole frame.
    task automatic push_frame(input int base);
        logic [24:0] a;
        for (int r = 0; r < RPF; r++) begin
            for (int c = 0; c < 1024; c++) begin
                a = {15'(base + r), 10'(c)};
                req_q.push_back(a);
                pix_q.push_back({(r == RPF - 1) && (c == 1023), word_of(a)});
            end
        end
    endtask

    // SDRAM model: checks each accepted request, returns data LAT cycles later.
    logic       pv [LAT];
    logic [9:0] pd [LAT];
    always @(negedge clk) begin
        logic [24:0] e;
        if (reset) begin
            for (int i = 0; i < LAT; i++) pv[i] = 1'b0;
            mdl_valid = 1'b0;
            req_q.delete();
        end else begin
            mdl_valid = pv[LAT-1];
            mdl_data  = pd[LAT-1];
            for (int i = LAT - 1; i > 0; i--) begin
                pv[i] = pv[i-1];
                pd[i] = pd[i-1];
            end
            pv[0] = 1'b0;
            if (bus.read && !bus.busy) begin
                acc_total++;
                checks++;
                if (req_q.size() == 0) begin
                    errors++;
                    $display("FAIL req_unexpected: got address %0h expected no request", bus.address);
                end else begin
                    e = req_q.pop_front();
                    if (bus.address !== e) begin
                        errors++;
                        $display("FAIL req_addr: got %0h expected %0h", bus.address, e);
                    end
                end
                pv[0] = 1'b1;
                pd[0] = word_of(bus.address);
            end
        end
    end

    // Pixel monitor: pops the scoreboard on every stream handshake.
    always @(negedge clk) begin
        logic [10:0] e;
        if (done) done_total++;
        if (reset) begin
            pix_q.delete();
        end else if (bus.pixelValid && bus.pixelReady) begin
            hs_total++;
            if (pix_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pix_unexpected: got %0h expected no pixel", bus.pixelData);
            end else begin
                e = pix_q.pop_front();
                chk("pix_data", 32'(bus.pixelData), 32'(e[9:0]));
                chk("pix_last", 32'(bus.pixelLast), 32'(e[10]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [14:0] lf);
        lastframe = lf;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_frame(input string name, input int d0);
        int n = 0;
        while (!done && n < PIX + 400) begin
            tick();
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_done_timeout: got no done after %0d cycles expected done", name, n);
        end
        chk({name, "_active_after_done"}, 32'(active), 32'd0);
        repeat (3) tick();
        chk({name, "_done_pulses"}, 32'(done_total - d0), 32'd1);
        chk({name, "_req_left"}, 32'(req_q.size()), 32'd0);
        chk({name, "_pix_left"}, 32'(pix_q.size()), 32'd0);
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_read"}, 32'(bus.read), 32'd0);
        chk({name, "_address"}, 32'(bus.address), 32'd0);
        chk({name, "_keepOpen"}, 32'(bus.keepOpen), 32'd0);
        chk({name, "_pixelData"}, 32'(bus.pixelData), 32'd0);
        chk({name, "_pixelValid"}, 32'(bus.pixelValid), 32'd0);
        chk({name, "_pixelLast"}, 32'(bus.pixelLast), 32'd0);
        chk({name, "_active"}, 32'(active), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int a0;
        int d0;
        int h0;
        int n;

        bus.busy = 1'b0;
        bus.pixelReady = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check_idle_outputs("reset");
        tick();

        // Basic frame: lastframe 4 -> base 2, busy burst and ignored start mid-frame.
        d0 = done_total;
        a0 = acc_total;
        push_frame(2);
        do_start(15'd4);
        chk("basic_active", 32'(active), 32'd1);
        chk("basic_first_read", 32'(bus.read), 32'd1);
        chk("basic_first_addr", 32'(bus.address), 32'({15'd2, 10'd0}));
        chk("basic_keepOpen", 32'(bus.keepOpen), 32'd1);
        n = 0;
        while (acc_total - a0 < 100 && n < 1000) begin
            tick();
            n++;
        end
        chk("basic_reach_100", 32'(acc_total - a0), 32'd100);
        bus.busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("busy_read_held", 32'(bus.read), 32'd1);
            chk("busy_addr_held", 32'(bus.address), 32'({15'd2, 10'd100}));
            tick();
        end
        bus.busy = 1'b0;
        repeat (10) tick();
        do_start(15'd20);
        chk("start_ignored_active", 32'(active), 32'd1);
        finish_frame("basic", d0);

        // Spurious return with nothing outstanding must not reach the stream.
        inj_data = 10'h3AB;
        inj_valid = 1'b1;
        tick();
        inj_valid = 1'b0;
        repeat (3) tick();
        chk("spurious_dropped", 32'(bus.pixelValid), 32'd0);

        // Wrap: lastframe 0 -> base (NF-1)*RPF = 30.
        d0 = done_total;
        push_frame(30);
        do_start(15'd0);
        chk("wrap_first_addr", 32'(bus.address), 32'({15'd30, 10'd0}));
        finish_frame("wrap", d0);

        // Backpressure: only FIFO_DEPTH requests may be issued.
        bus.pixelReady = 1'b0;
        d0 = done_total;
        a0 = acc_total;
        push_frame(4);
        do_start(15'd6);
        repeat (40) tick();
        chk("bp_requests", 32'(acc_total - a0), 32'd16);
        chk("bp_read_low", 32'(bus.read), 32'd0);
        chk("bp_fifo_valid", 32'(bus.pixelValid), 32'd1);
        bus.pixelReady = 1'b1;
        tick();
        chk("bp_read_resume", 32'(bus.read), 32'd1);
        finish_frame("bp", d0);

        // Reset mid-frame, then replay from a freshly latched base.
        push_frame(8);
        do_start(15'd10);
        h0 = hs_total;
        n = 0;
        while (hs_total - h0 < 1000 && n < 3000) begin
            tick();
            n++;
        end
        chk("rst_reach_1000", 32'(hs_total - h0), 32'd1000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle_outputs("midreset");
        tick();
        d0 = done_total;
        push_frame(18);
        do_start(15'd20);
        chk("replay_first_addr", 32'(bus.address), 32'({15'd18, 10'd0}));
        finish_frame("replay", d0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
